// File: rtl/input_matrix_mapper_pkg.sv
// Shared types and address-map constants for the input matrix mapper.
// A map entry is one byte: {active_low, button index}. Index 7'h7F marks an
// unused entry. Address offsets below are relative to M = NUM_STROBES*K_WIDTH.
package input_matrix_mapper_pkg;

   typedef struct packed {
      logic       active_low;
      logic [6:0] index;
   } input_map_entry_t;

   localparam logic [6:0] INPUT_UNUSED = 7'h7F;

   // Value every entry takes out of reset: unused, active high, decodes to 0.
   localparam input_map_entry_t ENTRY_RESET = '{active_low: 1'b0, index: INPUT_UNUSED};

   // Offsets of the non-matrix config registers, relative to M.
   localparam int GROUNDED_OFS = 0;
   localparam int BETA_OFS     = 1;
   localparam int BA_OFS       = 2;
   localparam int ACL_OFS      = 3;
   localparam int TURBO_OFS    = 4;

   // Apply an entry's polarity bit to the looked-up button level.
   function automatic logic apply_polarity(input input_map_entry_t e, input logic pressed);
      return pressed ^ e.active_low;
   endfunction

endpackage

// File: rtl/input_matrix_mapper_debounce.sv
// Single-button conditioner: two-flop synchroniser followed by a stability
// counter. The debounced level flips only after the synchronised input has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles, giving a
// press-to-stable latency of 2 + DEBOUNCE_CYCLES cycles. DEBOUNCE_CYCLES = 0
// bypasses the counter and exposes the synchroniser output directly.
module input_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable
);

   logic [1:0] sync_q;

   // Bring the asynchronous button into the clock domain.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values; blocking here would collapse the two sync stages into one.
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], raw};
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_sync_only
         assign stable = sync_q[1];
      end else begin : g_counter
         localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

         logic [CNT_W-1:0] cnt_q;
         logic             stable_q;

         // Count consecutive disagreements; flip the stable level on the last one.
         always_ff @(posedge clk) begin
            if (reset) begin
               cnt_q    <= '0;
               stable_q <= 1'b0;
            end else if (sync_q[1] == stable_q) begin
               cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_q    <= '0;
               stable_q <= ~stable_q;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end

         assign stable = stable_q;
      end
   endgenerate

endmodule

// File: rtl/input_matrix_mapper.sv
// Maps NUM_BUTTONS debounced buttons onto an NUM_STROBES x K_WIDTH key matrix
// plus the beta/BA/ACL lines of an SM5xx/SM510-style core. The mapping lives
// in byte-wide config registers written through cfg_wr/cfg_addr/cfg_data.
// K path: stage 1 registers the strobed-row OR and the grounded row, stage 2
// registers their union, so strobe -> K is two cycles. beta/BA/ACL are one cycle.
// Optional feature: define INPUT_MATRIX_TURBO_EN to add per-button autofire
// mask bytes (at M+4..) and a free-running phase toggling every TURBO_PERIOD cycles.
module input_matrix_mapper
   import input_matrix_mapper_pkg::*;
#(
   parameter int NUM_STROBES     = 8,
   parameter int K_WIDTH         = 4,
   parameter int NUM_BUTTONS     = 25,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TURBO_PERIOD    = 4096,
   parameter int CFG_ADDR_W      = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cfg_wr,
   input  logic [CFG_ADDR_W-1:0]  cfg_addr,
   input  logic [7:0]             cfg_data,
   input  logic [NUM_STROBES-1:0] strobe,
   input  logic [NUM_BUTTONS-1:0] buttons,
   output logic [K_WIDTH-1:0]     input_k,
   output logic                   input_beta,
   output logic                   input_ba,
   output logic                   input_acl
);

   localparam int M             = NUM_STROBES * K_WIDTH;
   localparam int ADDR_GROUNDED = M + GROUNDED_OFS;
   localparam int ADDR_BETA     = M + BETA_OFS;
   localparam int ADDR_BA       = M + BA_OFS;
   localparam int ADDR_ACL      = M + ACL_OFS;

   input_map_entry_t map_q [M];
   logic [7:0]       grounded_q;
   input_map_entry_t beta_q;
   input_map_entry_t ba_q;
   input_map_entry_t acl_q;

   logic [NUM_BUTTONS-1:0] debounced;
   logic [NUM_BUTTONS-1:0] effective;

   logic [NUM_STROBES-1:0][K_WIDTH-1:0] rows;
   logic [K_WIDTH-1:0] strobed_k;
   logic [K_WIDTH-1:0] grounded_sel_k;
   logic [K_WIDTH-1:0] row_k;
   logic [K_WIDTH-1:0] grounded_k;

   // Look up one entry: unused or out-of-range indices read as released.
   function automatic logic decode_entry(input input_map_entry_t e,
                                         input logic [NUM_BUTTONS-1:0] btn);
      logic pressed;
      pressed = 1'b0;
      for (int b = 0; b < NUM_BUTTONS; b++) begin
         if (e.index != INPUT_UNUSED && e.index == 7'(b)) pressed = btn[b];
      end
      return apply_polarity(e, pressed);
   endfunction

   // Per-button synchroniser and debounce.
   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
      input_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk   (clk),
         .reset (reset),
         .raw   (buttons[i]),
         .stable(debounced[i])
      );
   end

   // Config register file: matrix entries, grounded select, beta/BA/ACL entries.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the map is a few dozen flops rather than a RAM macro, so it gets a defined reset value like any other state.
         for (int i = 0; i < M; i++) map_q[i] <= ENTRY_RESET;
         grounded_q <= '0;
         beta_q     <= ENTRY_RESET;
         ba_q       <= ENTRY_RESET;
         acl_q      <= ENTRY_RESET;
      end else if (cfg_wr) begin
         for (int i = 0; i < M; i++) begin
            if (cfg_addr == CFG_ADDR_W'(i)) map_q[i] <= input_map_entry_t'(cfg_data);
         end
         if (cfg_addr == CFG_ADDR_W'(ADDR_GROUNDED)) grounded_q <= cfg_data;
         if (cfg_addr == CFG_ADDR_W'(ADDR_BETA))     beta_q     <= input_map_entry_t'(cfg_data);
         if (cfg_addr == CFG_ADDR_W'(ADDR_BA))       ba_q       <= input_map_entry_t'(cfg_data);
         if (cfg_addr == CFG_ADDR_W'(ADDR_ACL))      acl_q      <= input_map_entry_t'(cfg_data);
      end
   end

`ifdef INPUT_MATRIX_TURBO_EN
   localparam int ADDR_TURBO = M + TURBO_OFS;
   localparam int TURBO_W    = (TURBO_PERIOD > 1) ? $clog2(TURBO_PERIOD) : 1;

   logic [NUM_BUTTONS-1:0] turbo_mask;
   logic [TURBO_W-1:0]     turbo_cnt;
   logic                   turbo_phase;

   // Turbo mask bytes: byte j holds buttons 8j..8j+7.
   always_ff @(posedge clk) begin
      if (reset) begin
         turbo_mask <= '0;
      end else if (cfg_wr) begin
         for (int b = 0; b < NUM_BUTTONS; b++) begin
            if (cfg_addr == CFG_ADDR_W'(ADDR_TURBO + b / 8)) turbo_mask[b] <= cfg_data[b % 8];
         end
      end
   end

   // Free-running autofire phase, toggling every TURBO_PERIOD cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         turbo_cnt   <= '0;
         turbo_phase <= 1'b0;
      end else if (turbo_cnt == TURBO_W'(TURBO_PERIOD - 1)) begin
         turbo_cnt   <= '0;
         turbo_phase <= ~turbo_phase;
      end else begin
         turbo_cnt <= turbo_cnt + 1'b1;
      end
   end

   assign effective = debounced & (~turbo_mask | {NUM_BUTTONS{turbo_phase}});
`else
   assign effective = debounced;
`endif

   // Decode every matrix row, OR the strobed ones and pick the grounded one.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path can leave one unassigned and infer a latch.
      rows           = '0;
      strobed_k      = '0;
      grounded_sel_k = '0;
      for (int s = 0; s < NUM_STROBES; s++) begin
         for (int k = 0; k < K_WIDTH; k++) begin
            rows[s][k] = decode_entry(map_q[s * K_WIDTH + k], effective);
         end
      end
      for (int s = 0; s < NUM_STROBES; s++) begin
         if (strobe[s]) strobed_k = strobed_k | rows[s];
         if (grounded_q == 8'(s + 1)) grounded_sel_k = rows[s];
      end
   end

   // Two-stage K pipeline: register row terms, then their union.
   always_ff @(posedge clk) begin
      if (reset) begin
         row_k      <= '0;
         grounded_k <= '0;
         input_k    <= '0;
      end else begin
         row_k      <= strobed_k;
         grounded_k <= grounded_sel_k;
         input_k    <= row_k | grounded_k;
      end
   end

   // Register the decoded beta/BA/ACL lines.
   always_ff @(posedge clk) begin
      if (reset) begin
         input_beta <= 1'b0;
         input_ba   <= 1'b0;
         input_acl  <= 1'b0;
      end else begin
         input_beta <= decode_entry(beta_q, effective);
         input_ba   <= decode_entry(ba_q, effective);
         input_acl  <= decode_entry(acl_q, effective);
      end
   end

endmodule

// File: tb/tb_input_matrix_mapper.sv
// Self-checking bench for input_matrix_mapper (default build, turbo disabled).
// A reference model samples the bench's own stimulus at each rising edge and
// pushes the expected K and beta/BA/ACL values, tagged with the cycle they are
// due, into queues; a monitor on the falling edge pops and compares them.
// Directed sequences exercise the documented scenarios, then random traffic.
module tb_input_matrix_mapper;

   localparam int NS = 8;
   localparam int KW = 4;
   localparam int NB = 25;
   localparam int DC = 16;
   localparam int M  = NS * KW;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_wr;
   logic [7:0]  cfg_addr;
   logic [7:0]  cfg_data;
   logic [7:0]  strobe;
   logic [24:0] buttons;
   logic [3:0]  input_k;
   logic        input_beta;
   logic        input_ba;
   logic        input_acl;

   always #5 clk = ~clk;

   input_matrix_mapper #(
      .NUM_STROBES(NS), .K_WIDTH(KW), .NUM_BUTTONS(NB),
      .DEBOUNCE_CYCLES(DC), .TURBO_PERIOD(4096), .CFG_ADDR_W(8)
   ) dut (
      .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .strobe(strobe), .buttons(buttons),
      .input_k(input_k), .input_beta(input_beta), .input_ba(input_ba),
      .input_acl(input_acl)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   typedef struct { int due; logic [3:0] k; } k_exp_t;
   typedef struct { int due; logic [2:0] lines; } ln_exp_t;
   k_exp_t  k_q  [$];
   ln_exp_t ln_q [$];

   // Model state: config bytes, debounced levels, recent raw samples (newest first).
   bit [7:0]  m_map [M];
   bit [7:0]  m_gnd, m_beta, m_ba, m_acl;
   bit [24:0] m_stable;
   bit [24:0] m_hist [$];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic bit dec(input bit [7:0] e, input bit [24:0] b);
      int idx;
      bit v;
      idx = int'(e[6:0]);
      v = (idx < NB) ? b[idx] : 1'b0;
      return v ^ e[7];
   endfunction

   function automatic bit [3:0] model_k(input bit [7:0] s, input bit [7:0] g, input bit [24:0] b);
      bit [3:0] k;
      bit v;
      k = '0;
      for (int r = 0; r < NS; r++) begin
         for (int c = 0; c < KW; c++) begin
            v = dec(m_map[r * KW + c], b);
            if (s[r] && v) k[c] = 1'b1;
            if (int'(g) == r + 1 && v) k[c] = 1'b1;
         end
      end
      return k;
   endfunction

   task automatic push_k(input int due, input logic [3:0] k);
      k_exp_t e;
      e.due = due;
      e.k = k;
      k_q.push_back(e);
   endtask

   task automatic push_ln(input int due, input logic [2:0] l);
      ln_exp_t e;
      e.due = due;
      e.lines = l;
      ln_q.push_back(e);
   endtask

   task automatic model_reset();
      for (int i = 0; i < M; i++) m_map[i] = 8'h7F;
      m_gnd = '0;
      m_beta = 8'h7F;
      m_ba = 8'h7F;
      m_acl = 8'h7F;
      m_stable = '0;
      m_hist.delete();
      for (int i = 0; i <= DC; i++) m_hist.push_back('0);
   endtask

   // Reference model: one step per rising edge.
   initial begin
      bit [24:0] nxt;
      bit        all_diff;
      int        a;
      model_reset();
      forever begin
         @(posedge clk);
         if (reset) begin
            model_reset();
            k_q.delete();
            ln_q.delete();
            push_ln(cyc + 1, 3'b000);
            push_k(cyc + 1, 4'h0);
            push_k(cyc + 2, 4'h0);
         end else begin
            push_ln(cyc + 1, {dec(m_beta, m_stable), dec(m_ba, m_stable), dec(m_acl, m_stable)});
            push_k(cyc + 2, model_k(strobe, m_gnd, m_stable));
            // A button's level flips once its last DC synchronised samples all disagree with it.
            nxt = m_stable;
            for (int b = 0; b < NB; b++) begin
               all_diff = 1'b1;
               for (int i = 1; i <= DC; i++) begin
                  if (m_hist[i][b] == m_stable[b]) all_diff = 1'b0;
               end
               if (all_diff) nxt[b] = ~m_stable[b];
            end
            m_stable = nxt;
            if (cfg_wr) begin
               a = int'(cfg_addr);
               if (a < M) m_map[a] = cfg_data;
               else if (a == M) m_gnd = cfg_data;
               else if (a == M + 1) m_beta = cfg_data;
               else if (a == M + 2) m_ba = cfg_data;
               else if (a == M + 3) m_acl = cfg_data;
            end
            m_hist.push_front(buttons);
            void'(m_hist.pop_back());
         end
         cyc++;
      end
   end

   // Monitor: compare whatever is due this cycle.
   initial begin
      k_exp_t  ke;
      ln_exp_t le;
      forever begin
         @(negedge clk);
         while (k_q.size() > 0 && k_q[0].due <= cyc) begin
            ke = k_q.pop_front();
            if (ke.due == cyc) check("sb_input_k", {4'h0, input_k}, {4'h0, ke.k});
         end
         while (ln_q.size() > 0 && ln_q[0].due <= cyc) begin
            le = ln_q.pop_front();
            if (le.due == cyc) check("sb_beta_ba_acl", {5'h0, input_beta, input_ba, input_acl}, {5'h0, le.lines});
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cfg_write(input int a, input logic [7:0] d);
      cfg_wr = 1'b1;
      cfg_addr = 8'(a);
      cfg_data = d;
      @(negedge clk);
      cfg_wr = 1'b0;
   endtask

   function automatic logic [7:0] lines_now();
      return {5'h0, input_beta, input_ba, input_acl};
   endfunction

   // Stimulus
   initial begin
      int b;
      int a;
      reset = 1'b1;
      cfg_wr = 1'b0;
      cfg_addr = '0;
      cfg_data = '0;
      strobe = 8'h01;
      buttons = 25'($urandom);
      tick(3);
      check("reset_k", {4'h0, input_k}, 8'h00);
      check("reset_lines", lines_now(), 8'h00);

      // Default map with arbitrary buttons held: nothing reaches the core.
      reset = 1'b0;
      tick(20);
      check("idle_k", {4'h0, input_k}, 8'h00);
      check("idle_lines", lines_now(), 8'h00);
      buttons = '0;
      tick(20);

      // Entry 1 (s0,k1) -> button 5; K appears exactly two cycles after the strobe.
      cfg_write(1, 8'h05);
      strobe = 8'h00;
      buttons = 25'(1) << 5;
      tick(20);
      strobe = 8'h01;
      tick(1);
      check("k_latency_1cyc", {4'h0, input_k}, 8'h00);
      tick(1);
      check("k_s0_btn5", {4'h0, input_k}, 8'h02);
      strobe = 8'h02;
      tick(2);
      check("k_s1_empty", {4'h0, input_k}, 8'h00);

      // Release, then a 10-cycle glitch must never reach K.
      strobe = 8'h01;
      buttons = '0;
      tick(22);
      check("k_released", {4'h0, input_k}, 8'h00);
      for (int i = 0; i < 40; i++) begin
         buttons = (i < 10) ? (25'(1) << 5) : 25'(0);
         tick(1);
         check("k_glitch", {4'h0, input_k}, 8'h00);
      end

      // Grounded row 3 (s2): active-low entry for released button 3 forces k0.
      strobe = 8'h00;
      cfg_write(8, 8'h83);
      cfg_write(M, 8'd3);
      tick(3);
      check("k_grounded", {4'h0, input_k}, 8'h01);
      cfg_write(M, 8'd9);
      tick(3);
      check("k_grounded_oob", {4'h0, input_k}, 8'h00);
      cfg_write(M, 8'd0);

      // Two strobed rows OR together; beta/BA/ACL decode with polarity.
      cfg_write(0, 8'h00);
      cfg_write(4, 8'h01);
      cfg_write(M + 1, 8'h04);
      cfg_write(M + 2, 8'h85);
      cfg_write(M + 3, 8'h10);
      buttons = 25'b1_0011;
      strobe = 8'h03;
      tick(20);
      check("k_or_rows", {4'h0, input_k}, 8'h01);
      check("lines_mixed", lines_now(), 8'h06);
      cfg_write(M + 3, 8'hFF);
      cfg_write(M + 2, 8'h1E);
      cfg_write(M + 1, 8'h9E);
      tick(2);
      check("lines_unused_idx", lines_now(), 8'h05);

      // Turbo-mask and unmapped addresses change nothing in this build.
      cfg_write(M + 4, 8'hFF);
      cfg_write(200, 8'hFF);
      tick(3);
      check("k_after_ignored", {4'h0, input_k}, 8'h01);
      check("lines_after_ignored", lines_now(), 8'h05);

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         strobe = 8'($urandom);
         if ($urandom_range(0, 5) == 0) begin
            b = $urandom_range(0, NB - 1);
            buttons[b] = ~buttons[b];
         end
         if ($urandom_range(0, 9) == 0) begin
            a = $urandom_range(0, M + 8);
            cfg_wr = 1'b1;
            cfg_addr = 8'(a);
            if (a == M) cfg_data = 8'($urandom_range(0, 10));
            else if ($urandom_range(0, 7) == 0) cfg_data = $urandom_range(0, 1) ? 8'hFF : 8'h7F;
            else cfg_data = {1'($urandom), 7'($urandom_range(0, 31))};
         end else begin
            cfg_wr = 1'b0;
         end
         tick(1);
      end
      cfg_wr = 1'b0;

      // Reset mid-scan discards everything in flight.
      strobe = 8'hFF;
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("k_midscan_reset", {4'h0, input_k}, 8'h00);
      check("lines_midscan_reset", lines_now(), 8'h00);
      tick(1);
      check("k_midscan_reset_next", {4'h0, input_k}, 8'h00);
      tick(4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
